// File: rtl/data_sram8_ctrl.sv
// CPU data-port responder that serves 32-bit requests as a sequence of byte accesses
// to an 8-bit asynchronous SRAM, holding the pipeline until the word is complete.
module data_sram8_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              flush_i,
  output logic [31:0]       cpu_data_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [7:0]        sram_dq_o,
  input  logic [7:0]        sram_dq_i,
  output logic              sram_dq_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-3:0]   base_q, base_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          lane_q, lane_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         rbuf_q, rbuf_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dq_q, dq_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [2:0]          scan;

  // Word-offset and upper address bits are not part of the SRAM byte address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_W], cpu_addr_i[1:0]};

  // Returns {found, lane}: lowest byte offset >= start whose enable bit is set.
  function automatic logic [2:0] next_lane(input logic [3:0] sel, input logic [2:0] start);
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (k >= int'(start) && sel[3-k]) res = {1'b1, 2'(k)};
    end
    return res;
  endfunction

  // NOTE: state and data registers use non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    base_d  = base_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    data_d  = data_q;
    scan    = 3'b000;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (cpu_ce_i) begin
          we_d    = cpu_we_i;
          base_d  = cpu_addr_i[ADDR_W-1:2];
          sel_d   = cpu_sel_i;
          wdata_d = cpu_data_i;
          rbuf_d  = '0;
          scan    = next_lane(cpu_sel_i, 3'd0);
          if (scan[2]) begin
            lane_d  = scan[1:0];
            state_d = S_SETUP;
          end else begin
            data_d  = '0;
            state_d = S_DONE;
          end
        end
        S_SETUP: begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_STROBE;
        end
        S_STROBE: begin
          if (cnt_q == 4'd0) begin
            if (!we_q) rbuf_d[{~lane_q, 3'b000} +: 8] = sram_dq_i;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_HOLD: begin
          scan = next_lane(sel_q, {1'b0, lane_q} + 3'd1);
          if (scan[2]) begin
            lane_d  = scan[1:0];
            state_d = S_SETUP;
          end else begin
            // The assembled word is published only on completion, so a flush
            // part-way through a read never disturbs cpu_data_o.
            if (!we_q) data_d = rbuf_q;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // SRAM pins are registered from the next state so they change only at clock edges.
  always_comb begin
    addr_d  = addr_q;
    dq_d    = dq_q;
    dq_oe_d = 1'b0;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    unique case (state_d)
      S_SETUP: begin
        ce_n_d  = 1'b0;
        dq_oe_d = we_d;
        addr_d  = {base_d, lane_d};
        if (we_d) dq_d = wdata_d[{~lane_d, 3'b000} +: 8];
      end
      S_STROBE: begin
        ce_n_d  = 1'b0;
        dq_oe_d = we_d;
        oe_n_d  = we_d;
        we_n_d  = ~we_d;
      end
      S_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = we_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      base_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      we_q    <= we_d;
      base_q  <= base_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign stallreq_o   = cpu_ce_i && (state_q != S_DONE) && !flush_i;
  assign cpu_data_o   = data_q;
  assign sram_addr_o  = addr_q;
  assign sram_dq_o    = dq_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;

endmodule

// File: tb/tb_data_sram8_ctrl.sv
// Bench for data_sram8_ctrl: byte-wide async SRAM model, table of requests with a
// scoreboard of expected results, plus flush and mid-access reset sequences.
module tb_data_sram8_ctrl;
  localparam int ADDR_W      = 20;
  localparam int WAIT_CYCLES = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_ce_i, cpu_we_i, flush_i;
  logic [31:0]       cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]        cpu_sel_i;
  logic              stallreq_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [7:0]        sram_dq_o, sram_dq_i;
  logic              sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;

  always #5 clk = ~clk;

  data_sram8_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .flush_i(flush_i),
    .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o),
    .sram_addr_o(sram_addr_o), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o),
    .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o)
  );

  // Asynchronous SRAM: read is combinational, write latches on the rising edge of we_n.
  logic [7:0]  mem [0:2047];
  logic [27:0] wlog [$];
  int          rd_strobes = 0;
  int          overlap = 0;

  assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[10:0]] : 8'h00;

  always @(posedge sram_we_n_o) begin
    if (!sram_ce_n_o && sram_dq_oe_o) begin
      mem[sram_addr_o[10:0]] = sram_dq_o;
      wlog.push_back({sram_addr_o, sram_dq_o});
    end
  end
  always @(negedge sram_oe_n_o) rd_strobes++;
  always @(negedge clk) if (sram_oe_n_o === 1'b0 && sram_we_n_o === 1'b0) overlap++;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic [31:0] exp_data;
    int          exp_stall;
    int          exp_rd;
  } sb_t;

  sb_t sb [$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request and keeps cpu_ce_i high until the DONE cycle; the request
  // inputs are inverted after the first edge to show only the latched copy is used.
  task automatic do_req(input vec_t v, input string tag);
    sb_t         e;
    logic [27:0] ew [$];
    int          stall;
    bit          done;
    logic [31:0] got;
    e.exp_data  = v.exp_data;
    e.exp_stall = v.exp_stall;
    e.exp_rd    = v.we ? 0 : $countones(v.sel);
    sb.push_back(e);
    for (int k = 0; k < 4; k++)
      if (v.we && v.sel[3-k]) ew.push_back({v.addr[ADDR_W-1:2], 2'(k), v.wdata[8*(3-k) +: 8]});
    wlog.delete();
    rd_strobes = 0;
    cpu_we_i = v.we; cpu_addr_i = v.addr; cpu_sel_i = v.sel; cpu_data_i = v.wdata;
    cpu_ce_i = 1'b1;
    stall = 0; done = 1'b0; got = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (stallreq_o) stall++;
      else begin done = 1'b1; got = cpu_data_o; end
      if (!done) begin
        @(posedge clk); #1;
        if (c == 0) begin
          cpu_we_i = ~v.we; cpu_addr_i = ~v.addr; cpu_sel_i = ~v.sel; cpu_data_i = ~v.wdata;
        end
      end
    end
    @(posedge clk); #1;
    cpu_ce_i = 1'b0;
    e = sb.pop_front();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_data"}, got, e.exp_data);
    check({tag, "_stall"}, 32'(stall), 32'(e.exp_stall));
    check({tag, "_rd_strobes"}, 32'(rd_strobes), 32'(e.exp_rd));
    check({tag, "_wr_count"}, 32'(wlog.size()), 32'(ew.size()));
    for (int i = 0; i < ew.size() && i < wlog.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(wlog[i]), 32'(ew[i]));
  endtask

  vec_t        vecs [11];
  vec_t        post;
  logic [31:0] last_data;
  bit          found;

  initial begin
    // Per-lane cost is SETUP + (WAIT_CYCLES+1) STROBE + HOLD = 4 cycles, plus 1 IDLE cycle.
    vecs[0]  = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'h1122_3344, 17};
    vecs[1]  = '{1'b1, 32'h0000_0205, 4'b0100, 32'hA5A5_A5A5, 32'h1122_3344, 5};
    vecs[2]  = '{1'b1, 32'h0000_0300, 4'b0111, 32'h00DE_ADBE, 32'h1122_3344, 13};
    vecs[3]  = '{1'b0, 32'h0000_0300, 4'b0111, 32'h0,         32'h00DE_ADBE, 13};
    vecs[4]  = '{1'b0, 32'h0000_0204, 4'b0100, 32'h0,         32'h00A5_0000, 5};
    vecs[5]  = '{1'b0, 32'h0000_0100, 4'b1001, 32'h0,         32'h1100_0044, 9};
    vecs[6]  = '{1'b0, 32'h0000_0102, 4'b0000, 32'h0,         32'h0000_0000, 1};
    vecs[7]  = '{1'b1, 32'h0000_0400, 4'b1010, 32'hCAFE_BABE, 32'h0000_0000, 9};
    vecs[8]  = '{1'b0, 32'h0000_0400, 4'b1111, 32'h0,         32'hCA00_BA00, 17};
    vecs[9]  = '{1'b0, 32'h0000_0400, 4'b0010, 32'h0,         32'h0000_BA00, 5};
    vecs[10] = '{1'b0, 32'hFFF0_0100, 4'b0001, 32'h0,         32'h0000_0044, 5};
    post     = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'h1122_3344, 17};

    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h100] = 8'h11; mem[11'h101] = 8'h22; mem[11'h102] = 8'h33; mem[11'h103] = 8'h44;

    rst = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; flush_i = 1'b0;
    cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", {27'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o, stallreq_o}, 32'b11100);
    check("reset_data", cpu_data_o, 32'h0);
    check("reset_addr", 32'(sram_addr_o), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_req(vecs[i], $sformatf("vec%0d", i));
    last_data = vecs[10].exp_data;

    // Flush in SETUP of lane 2 of a full-word write: lanes 0-1 land, 2-3 never strobe.
    wlog.delete();
    cpu_we_i = 1'b1; cpu_addr_i = 32'h500; cpu_sel_i = 4'hF; cpu_data_i = 32'h0102_0304;
    cpu_ce_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (!sram_ce_n_o && sram_we_n_o && sram_addr_o == 20'h00502) found = 1'b1;
    end
    check("flushw_reached", 32'(found), 32'd1);
    flush_i = 1'b1;
    #1;
    check("flushw_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    check("flushw_pins", {28'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o}, 32'b1110);
    flush_i = 1'b0; cpu_ce_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("flushw_mem", {mem[11'h500], mem[11'h501], mem[11'h502], mem[11'h503]}, 32'h0102_0000);
    check("flushw_wr_count", 32'(wlog.size()), 32'd2);
    check("flushw_data", cpu_data_o, last_data);

    // Flush during the second lane of a read leaves the previous word on cpu_data_o.
    rd_strobes = 0;
    cpu_we_i = 1'b0; cpu_addr_i = 32'h100; cpu_sel_i = 4'hF; cpu_ce_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (rd_strobes >= 2) found = 1'b1;
    end
    check("flushr_reached", 32'(found), 32'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; cpu_ce_i = 1'b0;
    check("flushr_oe_n", 32'(sram_oe_n_o), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("flushr_data", cpu_data_o, last_data);

    // Asynchronous reset in the middle of a write strobe.
    cpu_we_i = 1'b1; cpu_addr_i = 32'h600; cpu_sel_i = 4'hF; cpu_data_i = 32'h5566_7788;
    cpu_ce_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (!sram_we_n_o) found = 1'b1;
    end
    check("rstmid_reached", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_pins", {28'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o}, 32'b1110);
    check("rstmid_addr", 32'(sram_addr_o), 32'h0);
    check("rstmid_data", cpu_data_o, 32'h0);
    cpu_ce_i = 1'b0;
    #1;
    check("rstmid_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(post, "post_reset");

    check("oe_we_overlap", 32'(overlap), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
